// File: rtl/puzzle_pkg.sv
// Shared types and constants for the colour-cycling puzzle engine.
package puzzle_pkg;

  typedef enum logic [1:0] {IDLE, SCRAMBLE, PLAY, WON} state_t;

  // line is wide enough for the largest legal grid (N = 8)
  typedef struct packed {
    logic [2:0] line;
    logic       col;
    logic       dec;
  } move_t;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/puzzle_lfsr.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11), loads SEED on reset.
module puzzle_lfsr
  import puzzle_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= SEED;
    else       q <= {1'b0, q[LFSR_W-1:1]} ^ (q[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/puzzle_grid_core.sv
// N x N colour-cycling puzzle: cell array, row/column moves, LFSR scramble, move counter, win detect.
// Optional one-deep undo of the last player move is built when PUZZLE_UNDO_EN is defined.
module puzzle_grid_core
  import puzzle_pkg::*;
#(
  parameter int          N              = 4,
  parameter int          W              = 2,
  parameter int          SCRAMBLE_MOVES = 16,
  parameter int          CNT_W          = 16,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_scramble,
  input  logic               fire,
  input  logic               sel_col,
  input  logic [N-1:0]       sel,
  input  logic               add_n,
  input  logic               undo,
  output logic [N*N*W-1:0]   cells,
  output logic               busy,
  output logic               sel_error,
  output logic               win,
  output logic [CNT_W-1:0]   move_count
);

  localparam int LW = $clog2(N);
  localparam int SW = $clog2(SCRAMBLE_MOVES + 1);

  state_t             state, state_nx;
  logic [SW-1:0]      scr_cnt, scr_cnt_nx;
  logic [CNT_W-1:0]   count_q, count_nx;
  logic               check_q, check_nx;
  logic [N*N*W-1:0]   cells_q, cells_d;
  logic [LFSR_W-1:0]  lfsr;
  logic [2:0]         sel_idx;
  logic               fire_go, undo_ok, solved, mv_en;
  move_t              mv, fire_mv, rnd_mv, undo_mv;
  logic               unused_lfsr;

  puzzle_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .reset(reset), .q(lfsr));
  assign unused_lfsr = ^lfsr;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++)
      if (sel[i]) sel_idx = 3'(i);
  end

  assign sel_error = ~((|sel) && ((sel & (sel - 1'b1)) == '0));
  assign fire_mv   = '{line: sel_idx, col: sel_col, dec: add_n};
  assign rnd_mv    = '{line: 3'(lfsr[LW-1:0]), col: lfsr[15], dec: 1'b0};
  assign fire_go   = fire && !sel_error && !start_scramble && (state == IDLE || state == PLAY);

`ifdef PUZZLE_UNDO_EN
  move_t undo_mv_q;
  logic  undo_vld_q;

  assign undo_ok = undo && undo_vld_q && (state == PLAY) && !fire_go && !start_scramble;
  assign undo_mv = '{line: undo_mv_q.line, col: undo_mv_q.col, dec: ~undo_mv_q.dec};

  always_ff @(posedge clk) begin
    if (reset) begin
      undo_vld_q <= 1'b0;
      undo_mv_q  <= '0;
    end else if (fire_go) begin
      undo_vld_q <= 1'b1;
      undo_mv_q  <= fire_mv;
    end else if (undo_ok || start_scramble) begin
      undo_vld_q <= 1'b0;
    end
  end
`else
  logic unused_undo;
  assign unused_undo = undo;
  assign undo_ok     = 1'b0;
  assign undo_mv     = '0;
`endif

  always_comb begin
    state_nx   = state;
    scr_cnt_nx = scr_cnt;
    count_nx   = count_q;
    check_nx   = 1'b0;
    mv_en      = 1'b0;
    mv         = fire_mv;
    if (start_scramble) begin
      state_nx   = SCRAMBLE;
      scr_cnt_nx = SW'(SCRAMBLE_MOVES);
    end else begin
      case (state)
        IDLE, PLAY: begin
          // win is judged on the board left by the previous player move
          if (state == PLAY && check_q && solved) state_nx = WON;
          if (fire_go) begin
            mv_en    = 1'b1;
            check_nx = 1'b1;
            state_nx = (state == IDLE) ? PLAY : state_nx;
            if (count_q != '1) count_nx = count_q + 1'b1;
          end else if (undo_ok) begin
            mv_en = 1'b1;
            mv    = undo_mv;
            if (count_q != '0) count_nx = count_q - 1'b1;
          end
        end
        SCRAMBLE: begin
          mv = rnd_mv;
          if (scr_cnt != '0) begin
            mv_en      = 1'b1;
            scr_cnt_nx = scr_cnt - 1'b1;
          end else if (solved) begin
            mv_en = 1'b1;
          end else begin
            count_nx = '0;
            state_nx = PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int IDX = (r * N + c) * W;
      logic         hit;
      logic [W-1:0] cur;
      assign cur = cells_q[IDX +: W];
      assign hit = mv_en && (mv.col ? (mv.line == 3'(c)) : (mv.line == 3'(r)));
      assign cells_d[IDX +: W] = hit ? (mv.dec ? cur - W'(1) : cur + W'(1)) : cur;
    end
  end

  logic [N*N-1:0] eq;
  for (genvar i = 0; i < N * N; i++) begin : g_eq
    assign eq[i] = (cells_q[i*W +: W] == cells_q[0 +: W]);
  end
  assign solved = &eq;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      scr_cnt <= '0;
      count_q <= '0;
      check_q <= 1'b0;
      cells_q <= '0;
    end else begin
      state   <= state_nx;
      scr_cnt <= scr_cnt_nx;
      count_q <= count_nx;
      check_q <= check_nx;
      cells_q <= cells_d;
    end
  end

  assign cells      = cells_q;
  assign busy       = (state == SCRAMBLE);
  assign win        = (state == WON);
  assign move_count = count_q;

endmodule

// File: tb/tb_puzzle_grid_core.sv
// Directed self-checking bench for puzzle_grid_core (4x4 default instance plus an 8x8, W=3, CNT_W=4 instance).
module tb_puzzle_grid_core;

  logic         clk = 1'b0;
  logic         reset, start_scramble, fire, sel_col, add_n, undo;
  logic [3:0]   sel;
  logic [31:0]  cells;
  logic         busy, sel_error, win;
  logic [15:0]  move_count;

  logic         start8, fire8, selcol8, addn8, undo8;
  logic [7:0]   sel8;
  logic [191:0] cells8;
  logic         busy8, selerr8, win8;
  logic [3:0]   cnt8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  puzzle_grid_core dut (
    .clk(clk), .reset(reset), .start_scramble(start_scramble), .fire(fire),
    .sel_col(sel_col), .sel(sel), .add_n(add_n), .undo(undo), .cells(cells),
    .busy(busy), .sel_error(sel_error), .win(win), .move_count(move_count)
  );

  puzzle_grid_core #(.N(8), .W(3), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .start_scramble(start8), .fire(fire8),
    .sel_col(selcol8), .sel(sel8), .add_n(addn8), .undo(undo8), .cells(cells8),
    .busy(busy8), .sel_error(selerr8), .win(win8), .move_count(cnt8)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic fire_move(input logic col, input logic [3:0] s, input logic dn);
    sel_col = col;
    sel     = s;
    add_n   = dn;
    fire    = 1'b1;
    step();
    fire    = 1'b0;
  endtask

  task automatic wait_scramble(output int n);
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("scramble_timeout", (n < 300), 1'b1);
  endtask

  function automatic logic is_solved(input logic [31:0] c);
    for (int i = 1; i < 16; i++)
      if (c[i*2 +: 2] != c[1:0]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] apply4(input logic [31:0] c, input logic col, input int idx, input logic dec);
    logic [31:0] res;
    logic [1:0]  v;
    res = c;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if ((col ? k : r) == idx) begin
          v = c[(r*4+k)*2 +: 2];
          v = dec ? v - 2'd1 : v + 2'd1;
          res[(r*4+k)*2 +: 2] = v;
        end
    return res;
  endfunction

  initial begin
    logic [31:0] snap, exp_c, run_a, run_b;
    int n;

    start_scramble = 0; fire = 0; sel_col = 0; add_n = 0; undo = 0; sel = '0;
    start8 = 0; fire8 = 0; selcol8 = 0; addn8 = 0; undo8 = 0; sel8 = '0;
    do_reset();

    chk("reset_cells", cells, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_win", win, 1'b0);
    chk("reset_count", move_count, 16'd0);
    chk("reset_cells8", cells8, 192'h0);

    // single row fire on row 1
    fire_move(1'b0, 4'b0010, 1'b0);
    chk("row1_cells", cells, 32'h0000_5500);
    chk("row1_count", move_count, 16'd1);
    step();
    chk("row1_win", win, 1'b0);

    // four row fires solve the board
    do_reset();
    fire_move(1'b0, 4'b0001, 1'b0);
    fire_move(1'b0, 4'b0010, 1'b0);
    fire_move(1'b0, 4'b0100, 1'b0);
    fire_move(1'b0, 4'b1000, 1'b0);
    chk("solve_cells", cells, 32'h5555_5555);
    chk("solve_count", move_count, 16'd4);
    chk("solve_win_t1", win, 1'b0);
    step();
    chk("solve_win_t2", win, 1'b1);
    fire_move(1'b0, 4'b0001, 1'b0);
    chk("won_fire_cells", cells, 32'h5555_5555);
    chk("won_fire_count", move_count, 16'd4);

    // scramble from WON
    start_scramble = 1'b1;
    step();
    start_scramble = 1'b0;
    chk("scr_busy_rise", busy, 1'b1);
    chk("scr_win_clear", win, 1'b0);
    wait_scramble(n);
    chk("scr_busy_len", (n >= 16), 1'b1);
    chk("scr_count", move_count, 16'd0);
    chk("scr_unsolved", is_solved(cells), 1'b0);

    // illegal select dropped
    snap = cells;
    sel  = 4'b0110;
    #1;
    chk("sel_err_hi", sel_error, 1'b1);
    fire_move(1'b0, 4'b0110, 1'b0);
    chk("sel_err_cells", cells, snap);
    chk("sel_err_count", move_count, 16'd0);
    sel = 4'b0100;
    #1;
    chk("sel_err_lo", sel_error, 1'b0);

    // legal row 0 increment on scrambled board
    exp_c = apply4(snap, 1'b0, 0, 1'b0);
    fire_move(1'b0, 4'b0001, 1'b0);
    chk("play_cells", cells, exp_c);
    chk("play_count", move_count, 16'd1);

`ifdef PUZZLE_UNDO_EN
    snap  = cells;
    exp_c = apply4(snap, 1'b1, 0, 1'b1);
    fire_move(1'b1, 4'b0001, 1'b1);
    chk("undo_pre_cells", cells, exp_c);
    chk("undo_pre_count", move_count, 16'd2);
    undo = 1'b1;
    step();
    undo = 1'b0;
    chk("undo_cells", cells, snap);
    chk("undo_count", move_count, 16'd1);
    undo = 1'b1;
    step();
    undo = 1'b0;
    chk("undo2_cells", cells, snap);
    chk("undo2_count", move_count, 16'd1);
`else
    snap = cells;
    undo = 1'b1;
    step();
    undo = 1'b0;
    chk("undo_ign_cells", cells, snap);
    chk("undo_ign_count", move_count, 16'd1);
`endif

    // start_scramble beats a simultaneous fire
    snap           = cells;
    start_scramble = 1'b1;
    fire           = 1'b1;
    sel            = 4'b0001;
    sel_col        = 1'b0;
    add_n          = 1'b0;
    step();
    start_scramble = 1'b0;
    fire           = 1'b0;
    chk("both_busy", busy, 1'b1);
    chk("both_cells", cells, snap);
    chk("both_count", move_count, 16'd1);
    wait_scramble(n);

    // identical seed and timing give an identical scramble
    do_reset();
    repeat (3) step();
    start_scramble = 1'b1;
    step();
    start_scramble = 1'b0;
    wait_scramble(n);
    run_a = cells;
    do_reset();
    repeat (3) step();
    start_scramble = 1'b1;
    step();
    start_scramble = 1'b0;
    wait_scramble(n);
    run_b = cells;
    chk("rerun_same", run_b, run_a);

    // 8x8, W=3, CNT_W=4 instance
    do_reset();
    selcol8 = 1'b0; sel8 = 8'h01; addn8 = 1'b0; fire8 = 1'b1;
    step();
    fire8 = 1'b0;
    chk("n8_row_cells", cells8, {168'h0, 24'h249249});
    chk("n8_row_count", cnt8, 4'd1);
    // column 0 alternately up and down keeps the board unsolved
    selcol8 = 1'b1;
    for (int i = 0; i < 14; i++) begin
      addn8 = i[0];
      fire8 = 1'b1;
      step();
      fire8 = 1'b0;
    end
    chk("n8_count15", cnt8, 4'd15);
    for (int i = 0; i < 2; i++) begin
      addn8 = i[0];
      fire8 = 1'b1;
      step();
      fire8 = 1'b0;
    end
    chk("n8_saturate", cnt8, 4'd15);
    chk("n8_cells_back", cells8, {168'h0, 24'h249249});
    step();
    chk("n8_win", win8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
